muldiv_ctrl: RTL and testbench

Multiply/divide sequencer for the five-stage pipeline: accepts mult/multu/div/divu/mthi/mtlo issued from the E stage, models the multi-cycle latency with a countdown, owns the HI/LO architectural registers and raises the D-stage stall when a mult/div-class instruction would collide with an in-flight operation. Sits beside the ALU in E; its operand inputs are the already-forwarded E-stage rs/rt values, and its hi/lo outputs feed the mfhi/mflo result path.

---
 rtl/md_pkg.sv | 30 +++
 rtl/muldiv_ctrl_if.sv | 22 ++
 rtl/md_arith.sv | 56 +++++
 rtl/muldiv_ctrl.sv | 95 +++++++++
 tb/tb_muldiv_ctrl.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM
// encoding and small op-class helpers.
package md_pkg;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   function automatic logic is_mul(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_MULTU);
   endfunction

   function automatic logic is_div(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   // Ops that occupy the unit for multiple cycles.
   function automatic logic is_arith(input logic [2:0] op);
      return is_mul(op) || is_div(op);
   endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// E-stage issue bundle and HI/LO/stall return path for the md sequencer.
interface muldiv_ctrl_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        md_in_d;
   logic        busy;
   logic        stall_md;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, rs_val, rt_val, md_in_d,
      input  busy, stall_md, hi, lo
   );

   modport slave (
      input  start, op, rs_val, rt_val, md_in_d,
      output busy, stall_md, hi, lo
   );
endinterface

// File: rtl/md_arith.sv
// Combinational mult/div datapath producing the {hi,lo} pair, including the
// divide-by-zero and signed-overflow corner results.
module md_arith
   import md_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic [63:0] result
);

   logic signed [63:0] rs_sx, rt_sx;
   logic        [63:0] prod_s, prod_u;
   logic signed [31:0] rs_s, rt_s, rt_s_safe, quo_s, rem_s;
   logic        [31:0] rt_u_safe, quo_u, rem_u;
   logic               div_zero, div_ovf;

   assign rs_sx  = {{32{rs_val[31]}}, rs_val};
   assign rt_sx  = {{32{rt_val[31]}}, rt_val};
   assign prod_s = rs_sx * rt_sx;
   assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

   assign div_zero = (rt_val == 32'd0);
   assign div_ovf  = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);

   // Divisors are forced to 1 in the special cases so the raw dividers never
   // see an undefined operand pair; those results are overridden below.
   assign rs_s      = rs_val;
   assign rt_s      = rt_val;
   assign rt_s_safe = (div_zero || div_ovf) ? 32'sd1 : rt_s;
   assign rt_u_safe = div_zero ? 32'd1 : rt_val;

   assign quo_s = rs_s / rt_s_safe;
   assign rem_s = rs_s % rt_s_safe;
   assign quo_u = rs_val / rt_u_safe;
   assign rem_u = rs_val % rt_u_safe;

   always_comb begin
      result = '0;
      case (op)
         OP_MULT:  result = prod_s;
         OP_MULTU: result = prod_u;
         OP_DIV: begin
            if (div_zero)     result = {rs_val, 32'hFFFF_FFFF};
            else if (div_ovf) result = {32'd0, 32'h8000_0000};
            else              result = {rem_s, quo_s};
         end
         OP_DIVU: begin
            if (div_zero) result = {rs_val, 32'hFFFF_FFFF};
            else          result = {rem_u, quo_u};
         end
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: holds HI/LO, models op latency with a countdown
// and requests a D-stage stall while an md op is in flight.
module muldiv_ctrl
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic            clk,
   input  logic            reset,
   muldiv_ctrl_if.slave    md
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW      = $clog2(MAX_CYC + 1);
   localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [31:0]    pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic [31:0]    hi_q, hi_d, lo_q, lo_d;
   logic [63:0]    arith_res;
   logic           arith_op, busy;

   md_arith u_arith (
      .op     (md.op),
      .rs_val (md.rs_val),
      .rt_val (md.rt_val),
      .result (arith_res)
   );

   assign arith_op = is_arith(md.op);
   assign busy     = (state_q == RUN);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         IDLE: begin
            if (md.start) begin
               if (arith_op) begin
                  // Result is computed up front; the countdown only models latency.
                  pend_hi_d = arith_res[63:32];
                  pend_lo_d = arith_res[31:0];
                  cnt_d     = is_mul(md.op) ? MULT_LD : DIV_LD;
                  state_d   = RUN;
               end else if (md.op == OP_MTHI) begin
                  hi_d = md.rs_val;
               end else if (md.op == OP_MTLO) begin
                  lo_d = md.rs_val;
               end
            end
         end
         RUN: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               hi_d    = pend_hi_q;
               lo_d    = pend_lo_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign md.busy     = busy;
   assign md.stall_md = md.md_in_d & (busy | (md.start & arith_op));
   assign md.hi       = hi_q;
   assign md.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: vector table of md ops plus hand sequences
// for stall timing, MT writes, start-while-busy and mid-run reset.
module tb_muldiv_ctrl;
   import md_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   muldiv_ctrl_if mif ();

   muldiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (mif.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int n_cyc(input logic [2:0] op);
      if (op == OP_MULT || op == OP_MULTU) return 5;
      if (op == OP_DIV || op == OP_DIVU) return 10;
      return 0;
   endfunction

   task automatic drive(input logic s, input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
      mif.start  = s;
      mif.op     = op;
      mif.rs_val = rs;
      mif.rt_val = rt;
   endtask

   initial begin
      logic [31:0] prev_hi, prev_lo;
      int          n;
      logic        busy_ok, stall_ok, stable_ok;

      vecs[0] = '{OP_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA};
      vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[2] = '{OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14};
      vecs[3] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[4] = '{OP_DIV,   32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF};
      vecs[5] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000};
      vecs[6] = '{OP_DIVU,  32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF};
      vecs[7] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD};
      vecs[8] = '{OP_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
      vecs[9] = '{OP_MTLO,  32'hDEAD_BEEF, 32'd0,        32'h3FFF_FFFF, 32'hDEAD_BEEF};

      reset       = 1'b1;
      mif.md_in_d = 1'b0;
      drive(1'b0, OP_MULT, 32'd0, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      chk("reset_busy",  {31'd0, mif.busy},     32'd0);
      chk("reset_stall", {31'd0, mif.stall_md}, 32'd0);
      chk("reset_hi",    mif.hi, 32'd0);
      chk("reset_lo",    mif.lo, 32'd0);

      // Table: issue, verify busy window and HI/LO stability, then result.
      for (int i = 0; i < 10; i++) begin
         prev_hi = mif.hi;
         prev_lo = mif.lo;
         n = n_cyc(vecs[i].op);
         drive(1'b1, vecs[i].op, vecs[i].rs, vecs[i].rt);
         tick();
         drive(1'b0, OP_MULT, 32'd0, 32'd0);
         busy_ok   = 1'b1;
         stable_ok = 1'b1;
         for (int k = 0; k < n; k++) begin
            if (mif.busy !== 1'b1) busy_ok = 1'b0;
            if (mif.hi !== prev_hi || mif.lo !== prev_lo) stable_ok = 1'b0;
            tick();
         end
         if (n > 0) begin
            chk($sformatf("v%0d_busy_window", i), {31'd0, busy_ok},   32'd1);
            chk($sformatf("v%0d_hilo_stable", i), {31'd0, stable_ok}, 32'd1);
         end
         chk($sformatf("v%0d_busy_done", i), {31'd0, mif.busy}, 32'd0);
         chk($sformatf("v%0d_hi", i), mif.hi, vecs[i].hi);
         chk($sformatf("v%0d_lo", i), mif.lo, vecs[i].lo);
      end

      // DIVU with md_in_d held: stall in the start cycle and all 10 busy cycles.
      mif.md_in_d = 1'b1;
      drive(1'b1, OP_DIVU, 32'd100, 32'd7);
      #1;
      chk("divu_stall_t0", {31'd0, mif.stall_md}, 32'd1);
      tick();
      drive(1'b0, OP_MULT, 32'd0, 32'd0);
      stall_ok = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (mif.stall_md !== 1'b1) stall_ok = 1'b0;
         tick();
      end
      chk("divu_stall_window", {31'd0, stall_ok}, 32'd1);
      chk("divu_stall_drop", {31'd0, mif.stall_md}, 32'd0);
      chk("divu_hi", mif.hi, 32'd2);
      chk("divu_lo", mif.lo, 32'd14);

      // MTHI: no stall, no busy, visible after the issuing edge.
      drive(1'b1, OP_MTHI, 32'h1234_5678, 32'd0);
      #1;
      chk("mthi_stall", {31'd0, mif.stall_md}, 32'd0);
      tick();
      drive(1'b0, OP_MULT, 32'd0, 32'd0);
      chk("mthi_hi",   mif.hi, 32'h1234_5678);
      chk("mthi_lo",   mif.lo, 32'd14);
      chk("mthi_busy", {31'd0, mif.busy}, 32'd0);
      mif.md_in_d = 1'b0;

      // A start arriving mid-run must be ignored.
      drive(1'b1, OP_MULT, 32'd6, 32'd7);
      tick();
      drive(1'b0, OP_MULT, 32'd0, 32'd0);
      tick();
      drive(1'b1, OP_DIVU, 32'd100, 32'd7);
      tick();
      drive(1'b0, OP_MULT, 32'd0, 32'd0);
      repeat (3) tick();
      chk("ignore_busy", {31'd0, mif.busy}, 32'd0);
      chk("ignore_hi", mif.hi, 32'd0);
      chk("ignore_lo", mif.lo, 32'd42);
      tick();
      chk("ignore_no_restart", {31'd0, mif.busy}, 32'd0);

      // Reset in the middle of a MULTU discards the in-flight result.
      drive(1'b1, OP_MULTU, 32'd3, 32'd4);
      tick();
      drive(1'b0, OP_MULT, 32'd0, 32'd0);
      tick();
      tick();
      chk("pre_reset_busy", {31'd0, mif.busy}, 32'd1);
      reset = 1'b1;
      #1;
      chk("midreset_busy", {31'd0, mif.busy}, 32'd0);
      chk("midreset_hi", mif.hi, 32'd0);
      chk("midreset_lo", mif.lo, 32'd0);
      tick();
      reset = 1'b0;
      repeat (8) tick();
      chk("postreset_busy", {31'd0, mif.busy}, 32'd0);
      chk("postreset_hi", mif.hi, 32'd0);
      chk("postreset_lo", mif.lo, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
